// File: rtl/dp_output_queue_bank.sv
// Bank of N independent first-word-fall-through output queues on clock_2x.
// Each queue exposes its head word, occupancy, empty/full and sticky error flags.
module dp_output_queue_bank #(
  parameter int unsigned N         = 1,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic                       clock_2x,
  input  logic                       reset,
  input  logic [N-1:0]               enqueue,
  input  logic [N*WIDTH-1:0]         data_in,
  input  logic [N-1:0]               dequeue,
  output logic [N*WIDTH-1:0]         data_out,
  output logic [N-1:0]               empty,
  output logic [N-1:0]               full,
  output logic [N*(LOG_DEPTH+1)-1:0] count,
  output logic [N-1:0]               overflow,
  output logic [N-1:0]               underflow
);

  localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
  localparam int unsigned CW    = LOG_DEPTH + 1;

  for (genvar i = 0; i < N; i++) begin : g_queue
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic                 empty_q;
    logic                 full_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 push_ok;
    logic                 pop_ok;

    // A push into a full queue is legal when the head leaves in the same cycle.
    always_comb begin
      pop_ok  = dequeue[i] & ~empty_q;
      push_ok = enqueue[i] & (~full_q | pop_ok);
      cnt_nxt = cnt + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointers, occupancy and flags; empty/full registered alongside count.
    always_ff @(posedge clock_2x) begin
      if (reset) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cnt     <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);
        cnt     <= cnt_nxt;
        empty_q <= (cnt_nxt == '0);
        full_q  <= (cnt_nxt == CW'(DEPTH));
        if (enqueue[i] & ~push_ok) ovf_q <= 1'b1;
        if (dequeue[i] & empty_q)  unf_q <= 1'b1;
      end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clock_2x) begin
      if (!reset && push_ok) mem[wr_ptr] <= data_in[i*WIDTH +: WIDTH];
    end

    assign data_out[i*WIDTH +: WIDTH] = mem[rd_ptr];
    assign count[i*CW +: CW]          = cnt;
    assign empty[i]                   = empty_q;
    assign full[i]                    = full_q;
    assign overflow[i]                = ovf_q;
    assign underflow[i]               = unf_q;
  end

endmodule

// File: tb/tb_dp_output_queue_bank.sv
// Self-checking bench for dp_output_queue_bank (N=2, DEPTH=8) against a queue-based model.
module tb_dp_output_queue_bank;

  logic        clock_2x = 1'b0;
  logic        reset    = 1'b0;
  logic [1:0]  enqueue  = '0;
  logic [63:0] data_in  = '0;
  logic [1:0]  dequeue  = '0;
  logic [63:0] data_out;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [7:0]  count;
  logic [1:0]  overflow;
  logic [1:0]  underflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [1:0]  m_ovf = '0;
  logic [1:0]  m_unf = '0;

  dp_output_queue_bank #(.N(2), .WIDTH(32), .LOG_DEPTH(3)) dut (
    .clock_2x (clock_2x),
    .reset    (reset),
    .enqueue  (enqueue),
    .data_in  (data_in),
    .dequeue  (dequeue),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clock_2x = ~clock_2x;

  // Expected {empty, full, count, overflow, underflow} from the model queues.
  function automatic logic [15:0] exp_status();
    logic [1:0] e, f;
    logic [7:0] c;
    e = {mq1.size() == 0, mq0.size() == 0};
    f = {mq1.size() == 8, mq0.size() == 8};
    c = {4'(mq1.size()), 4'(mq0.size())};
    return {e, f, c, m_ovf, m_unf};
  endfunction

  // Apply one clock edge with the given inputs and advance the model.
  task automatic step(input logic [1:0] enq, input logic [1:0] deq,
                      input logic [31:0] d0, input logic [31:0] d1, input logic rst);
    int s0, s1;
    bit p0, p1, u0, u1;
    reset   = rst;
    enqueue = enq;
    dequeue = deq;
    data_in = {d1, d0};
    @(posedge clock_2x);
    if (rst) begin
      mq0.delete();
      mq1.delete();
      m_ovf = '0;
      m_unf = '0;
    end else begin
      s0 = mq0.size();
      s1 = mq1.size();
      p0 = deq[0] && s0 > 0;
      p1 = deq[1] && s1 > 0;
      u0 = enq[0] && (s0 < 8 || p0);
      u1 = enq[1] && (s1 < 8 || p1);
      if (deq[0] && s0 == 0) m_unf[0] = 1'b1;
      if (deq[1] && s1 == 0) m_unf[1] = 1'b1;
      if (enq[0] && !u0) m_ovf[0] = 1'b1;
      if (enq[1] && !u1) m_ovf[1] = 1'b1;
      if (p0) void'(mq0.pop_front());
      if (p1) void'(mq1.pop_front());
      if (u0) mq0.push_back(d0);
      if (u1) mq1.push_back(d1);
    end
    #1;
    reset   = 1'b0;
    enqueue = '0;
    dequeue = '0;
  endtask

  task automatic test_reset();
    step(2'b00, 2'b00, 0, 0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({empty, full, count, overflow, underflow} !== 16'hC000) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got=%h want=%h", k,
                 {empty, full, count, overflow, underflow}, 16'hC000);
      end
      step(2'b00, 2'b00, 0, 0, 1'b0);
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 8; k++) begin
      step(2'b01, 2'b00, 32'hA0 + 32'(k), 0, 1'b0);
      checks++;
      if (count[3:0] !== 4'(k + 1) || full[0] !== 1'(k == 7)) begin
        errors++;
        $display("FAIL fill_count k=%0d got=%0d/%b want=%0d/%b", k, count[3:0], full[0], k + 1, k == 7);
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (data_out[31:0] !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL drain_head k=%0d got=%h want=%h", k, data_out[31:0], 32'hA0 + 32'(k));
      end
      step(2'b00, 2'b01, 0, 0, 1'b0);
      step(2'b00, 2'b00, 0, 0, 1'b0);
    end
    checks++;
    if (empty !== 2'b11 || count !== 8'h00) begin
      errors++;
      $display("FAIL drain_end got empty=%b count=%h want empty=11 count=00", empty, count);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 8; k++) step(2'b01, 2'b00, 32'hB0 + 32'(k), 0, 1'b0);
    step(2'b01, 2'b00, 32'hFF, 0, 1'b0);
    checks++;
    if (overflow[0] !== 1'b1 || count[3:0] !== 4'd8 || data_out[31:0] !== 32'hB0) begin
      errors++;
      $display("FAIL ovf_drop got ovf=%b cnt=%0d head=%h want ovf=1 cnt=8 head=b0",
               overflow[0], count[3:0], data_out[31:0]);
    end
    step(2'b01, 2'b01, 32'hEE, 0, 1'b0);
    checks++;
    if (count[3:0] !== 4'd8 || full[0] !== 1'b1 || data_out[31:0] !== 32'hB1) begin
      errors++;
      $display("FAIL full_push_pop got cnt=%0d full=%b head=%h want cnt=8 full=1 head=b1",
               count[3:0], full[0], data_out[31:0]);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (data_out[31:0] !== ((k < 7) ? 32'hB1 + 32'(k) : 32'hEE)) begin
        errors++;
        $display("FAIL ovf_drain k=%0d got=%h want=%h", k, data_out[31:0],
                 (k < 7) ? 32'hB1 + 32'(k) : 32'hEE);
      end
      step(2'b00, 2'b01, 0, 0, 1'b0);
      step(2'b00, 2'b00, 0, 0, 1'b0);
    end
    checks++;
    if ({empty, full, count, overflow, underflow} !== exp_status()) begin
      errors++;
      $display("FAIL ovf_status got=%h want=%h", {empty, full, count, overflow, underflow}, exp_status());
    end
  endtask

  task automatic test_underflow();
    step(2'b10, 2'b10, 0, 32'h55, 1'b0);
    checks++;
    if (underflow !== 2'b10 || count[7:4] !== 4'd1 || data_out[63:32] !== 32'h55) begin
      errors++;
      $display("FAIL unf_push got unf=%b cnt1=%0d head1=%h want unf=10 cnt1=1 head1=55",
               underflow, count[7:4], data_out[63:32]);
    end
    step(2'b00, 2'b10, 0, 0, 1'b0);
    checks++;
    if (empty[1] !== 1'b1 || underflow[1] !== 1'b1) begin
      errors++;
      $display("FAIL unf_sticky got empty1=%b unf1=%b want 1 1", empty[1], underflow[1]);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 20; r++) begin
      step(2'b01, 2'b00, 32'h100 + 32'(r), 0, 1'b0);
      checks++;
      if (data_out[31:0] !== 32'h100 + 32'(r) || count[3:0] !== 4'd1) begin
        errors++;
        $display("FAIL wrap r=%0d got head=%h cnt=%0d want head=%h cnt=1",
                 r, data_out[31:0], count[3:0], 32'h100 + 32'(r));
      end
      step(2'b00, 2'b01, 0, 0, 1'b0);
    end
    checks++;
    if (empty[0] !== 1'b1 || count[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL wrap_end got empty0=%b cnt=%0d want 1 0", empty[0], count[3:0]);
    end
  endtask

  task automatic test_reset_mid();
    step(2'b00, 2'b00, 0, 0, 1'b1);
    for (int k = 0; k < 9; k++) step(2'b01, 2'b00, 32'hC0 + 32'(k), 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 2'b01, 0, 0, 1'b0);
      step(2'b00, 2'b00, 0, 0, 1'b0);
    end
    checks++;
    if (count[3:0] !== 4'd5 || overflow[0] !== 1'b1 || data_out[31:0] !== 32'hC3) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d ovf=%b head=%h want cnt=5 ovf=1 head=c3",
               count[3:0], overflow[0], data_out[31:0]);
    end
    step(2'b01, 2'b00, 32'hDEAD, 0, 1'b1);
    checks++;
    if (count[3:0] !== 4'd0 || empty[0] !== 1'b1 || overflow !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d empty0=%b ovf=%b want 0 1 00", count[3:0], empty[0], overflow);
    end
    step(2'b01, 2'b00, 32'h11, 0, 1'b0);
    checks++;
    if (data_out[31:0] !== 32'h11 || count[3:0] !== 4'd1 || empty[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_push got head=%h cnt=%0d empty0=%b want 11 1 0",
               data_out[31:0], count[3:0], empty[0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] enq, deq;
    logic       rst;
    for (int c = 0; c < 400; c++) begin
      enq = 2'($urandom);
      deq = c[0] ? 2'($urandom) : 2'b00;
      rst = ($urandom_range(0, 149) == 0);
      step(enq, deq, $urandom, $urandom, rst);
      checks++;
      if ({empty, full, count, overflow, underflow} !== exp_status()) begin
        errors++;
        $display("FAIL rand_status c=%0d got=%h want=%h", c,
                 {empty, full, count, overflow, underflow}, exp_status());
      end
      if (mq0.size() > 0) begin
        checks++;
        if (data_out[31:0] !== mq0[0]) begin
          errors++;
          $display("FAIL rand_head0 c=%0d got=%h want=%h", c, data_out[31:0], mq0[0]);
        end
      end
      if (mq1.size() > 0) begin
        checks++;
        if (data_out[63:32] !== mq1[0]) begin
          errors++;
          $display("FAIL rand_head1 c=%0d got=%h want=%h", c, data_out[63:32], mq1[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_output_queue_bank.md
Name: dp_output_queue_bank

Overview:
- Bank of N independent first-word-fall-through (FWFT) output queues in the clock_2x domain.
- Consumes the phase-gated per-queue dequeue vector produced by the dequeue-gating stage, so each queue pops at most once per two clock_2x cycles.
- Presents each queue's head word, occupancy and status flags to the downstream double-pumped consumer.
- Storage per queue is a small register/distributed-RAM array.

Parameters:
N, 1, number of independent queues
WIDTH, 32, data word width in bits
LOG_DEPTH, 3, log2 of per-queue depth; DEPTH = 2**LOG_DEPTH (default 8)

Ports:
clock_2x  input  1  double-rate clock; sole clock of the block
reset  input  1  synchronous, active-high reset sampled on posedge clock_2x
enqueue  input  N  per-queue push strobe
data_in  input  N*WIDTH  push data; queue i uses bits [i*WIDTH +: WIDTH]
dequeue  input  N  per-queue pop strobe (already phase-gated upstream)
data_out  output  N*WIDTH  head word of each queue; queue i at [i*WIDTH +: WIDTH]
empty  output  N  queue i holds 0 words
full  output  N  queue i holds DEPTH words
count  output  N*(LOG_DEPTH+1)  occupancy of queue i, 0..DEPTH
overflow  output  N  sticky: push refused on a full queue
underflow  output  N  sticky: pop refused on an empty queue

Behaviour:
- Interface: one clock (clock_2x). Reset is synchronous and active-high (port reset). All state updates on posedge clock_2x.
- Reset (takes priority over all other inputs, including mid-operation):
  - write/read pointers = 0, count = 0
  - empty = all 1, full = all 0, overflow = underflow = all 0
  - storage array is not cleared; data_out is don't-care while empty.
- Per queue i (all queues fully independent, no shared arbitration):
  - push_ok = enqueue[i] & (!full[i] | pop_ok)
  - pop_ok = dequeue[i] & !empty[i]
  - push_ok: mem[wr_ptr] <= data_in slice; wr_ptr <= wr_ptr+1 mod DEPTH
  - pop_ok: rd_ptr <= rd_ptr+1 mod DEPTH
  - count <= count + push_ok - pop_ok; empty/full are derived from count and registered with it.
- FWFT: data_out = mem[rd_ptr]. It is a combinational read of registered state, with no read latency. It is valid whenever empty=0.
- Enqueue-to-visible latency: 1 cycle. A word pushed at edge k appears on data_out, and empty drops, after edge k.
- Pointer wrap: pointers wrap DEPTH-1 -> 0. count distinguishes full from empty when pointers are equal.
- Boundary conditions:
  - Push on full with no pop: data dropped, state unchanged, overflow[i] <= 1.
  - Push and pop on full: both accepted, count stays DEPTH. Popped word is the old head; new word is written at wr_ptr (== old rd_ptr slot just vacated), legal because the read is FWFT.
  - Pop on empty: ignored, underflow[i] <= 1. Push in the same cycle is still accepted; count becomes 1.
  - Push and pop on a non-empty, non-full queue: count unchanged, both pointers advance.
- Sticky flags clear only on reset.
- Arithmetic: count is LOG_DEPTH+1 bits unsigned and never exceeds DEPTH or goes below 0.
- No combinational path from enqueue/dequeue to any output. All outputs are derived from registers only.

Test Plan:
- Reset then idle (N=2, DEPTH=8) -> empty=2'b11, full=0, count=0, overflow=underflow=0 for 10 cycles.
- Push 0xA0..0xA7 into q0 on 8 consecutive cycles -> count0 steps 1..8, full[0]=1 after 8th edge. Then pop 8 on alternate cycles -> data_out0 sequence 0xA0..0xA7, empty[0]=1 at end. q1 stays untouched.
- Fill q0 (8 words), push 0xFF alone -> overflow[0]=1, count0=8, head unchanged. Next cycle push 0xEE and pop together -> count0=8, 0xEE emerges as 8th word after draining.
- Pop on empty q1 with simultaneous push 0x55 -> underflow[1]=1, count1=1, data_out1=0x55 next cycle.
- Wrap: 20 rounds of push-then-pop of an incrementing value on q0 -> every popped value matches, pointers wrap twice, count0 never exceeds 1.
- Assert reset with q0 holding 5 words and overflow set -> next cycle count0=0, empty[0]=1, overflow=0. A subsequent push 0x11 is visible as head one cycle later.
